sc_arb_node: RTL and testbench



---
 rtl/sc_arb_node_if.sv | 27 ++
 rtl/sc_arb_node.sv | 108 ++++++++++
 tb/tb_sc_arb_node.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/sc_arb_node_if.sv
// sc_arb_node_if: source-side and master-side send/recv handshake bundle for sc_arb_node.
// slave is the node's view; master is the view of the environment that drives it.
interface sc_arb_node_if #(
    parameter int NUM_SI  = 2,
    parameter int PAYLD_W = 174,
    parameter int INFO_W  = 1
);
    localparam int ID_W = (NUM_SI > 1) ? $clog2(NUM_SI) : 1;
    logic [NUM_SI-1:0]         s_sc_send;
    logic [NUM_SI-1:0]         s_sc_recv;
    logic [NUM_SI*PAYLD_W-1:0] s_sc_payld;
    logic [NUM_SI*INFO_W-1:0]  s_sc_info;
    logic                      m_sc_send;
    logic                      m_sc_recv;
    logic                      m_sc_req;
    logic [PAYLD_W-1:0]        m_sc_payld;
    logic [INFO_W-1:0]         m_sc_info;
    logic [ID_W-1:0]           m_sc_id;
    modport slave (
        input  s_sc_send, s_sc_payld, s_sc_info, m_sc_recv,
        output s_sc_recv, m_sc_send, m_sc_req, m_sc_payld, m_sc_info, m_sc_id
    );
    modport master (
        output s_sc_send, s_sc_payld, s_sc_info, m_sc_recv,
        input  s_sc_recv, m_sc_send, m_sc_req, m_sc_payld, m_sc_info, m_sc_id
    );
endinterface

// File: rtl/sc_arb_node.sv
// sc_arb_node: NUM_SI-to-1 round-robin merge node with an output FIFO and source-id tagging.
// Define SC_ARB_NODE_PKT_LOCK_EN to hold the grant on one source until payld[LAST_BIT] closes the packet.
module sc_arb_node #(
    parameter int NUM_SI     = 2,
    parameter int PAYLD_W    = 174,
    parameter int INFO_W     = 1,
    parameter int FIFO_DEPTH = 4,
    parameter int LAST_BIT   = 0
) (
    input logic          sc_clk,
    input logic          sc_reset,
    sc_arb_node_if.slave bus
);
    localparam int ID_W = (NUM_SI > 1) ? $clog2(NUM_SI) : 1;
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CW   = AW + 1;
    localparam int EW   = ID_W + INFO_W + PAYLD_W;

    logic [ID_W-1:0]   r_last_gnt;
    logic [AW-1:0]     r_wr;
    logic [AW-1:0]     r_rd;
    logic [CW-1:0]     r_count;
    logic [EW-1:0]     r_mem [FIFO_DEPTH];
    logic              w_hit;
    logic [ID_W-1:0]   w_sel;
    logic [NUM_SI-1:0] w_gnt;
    logic [NUM_SI-1:0] w_recv;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic [PAYLD_W-1:0] w_in_payld;
    logic [INFO_W-1:0] w_in_info;
    logic [EW-1:0]     w_head;
`ifdef SC_ARB_NODE_PKT_LOCK_EN
    logic              r_locked;
    logic [ID_W-1:0]   r_lock_id;
`endif

    // Search starts just after the last accepted source, so it gets lowest priority next.
    always_comb begin
        w_hit = 1'b0;
        w_sel = '0;
        for (int k = 1; k <= NUM_SI; k++) begin
            if (!w_hit && bus.s_sc_send[(int'(r_last_gnt) + k) % NUM_SI]) begin
                w_hit = 1'b1;
                w_sel = ID_W'((int'(r_last_gnt) + k) % NUM_SI);
            end
        end
`ifdef SC_ARB_NODE_PKT_LOCK_EN
        if (r_locked) begin
            w_hit = bus.s_sc_send[r_lock_id];
            w_sel = r_lock_id;
        end
`endif
        w_gnt = NUM_SI'(w_hit) << w_sel;
    end

    assign w_full     = (r_count == CW'(FIFO_DEPTH));
    assign w_empty    = (r_count == '0);
    assign w_recv     = w_gnt & {NUM_SI{!w_full && !sc_reset}};
    assign w_push     = |w_recv;
    assign w_pop      = !w_empty && bus.m_sc_recv;
    assign w_in_payld = bus.s_sc_payld[int'(w_sel)*PAYLD_W +: PAYLD_W];
    assign w_in_info  = bus.s_sc_info[int'(w_sel)*INFO_W +: INFO_W];
    assign w_head     = w_empty ? '0 : r_mem[r_rd];

    assign bus.s_sc_recv  = w_recv;
    assign bus.m_sc_send  = !w_empty;
    assign bus.m_sc_req   = !w_empty;
    assign bus.m_sc_payld = w_head[PAYLD_W-1:0];
    assign bus.m_sc_info  = w_head[PAYLD_W +: INFO_W];
    assign bus.m_sc_id    = w_head[PAYLD_W+INFO_W +: ID_W];

    always_ff @(posedge sc_clk) begin
        if (w_push)
            r_mem[r_wr] <= {w_sel, w_in_info, w_in_payld};
    end

    always_ff @(posedge sc_clk) begin
        if (sc_reset) begin
            r_wr       <= '0;
            r_rd       <= '0;
            r_count    <= '0;
            r_last_gnt <= ID_W'(NUM_SI - 1);
        end else begin
            if (w_push) begin
                r_wr       <= r_wr + 1'b1;
                r_last_gnt <= w_sel;
            end
            if (w_pop)
                r_rd <= r_rd + 1'b1;
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

`ifdef SC_ARB_NODE_PKT_LOCK_EN
    always_ff @(posedge sc_clk) begin
        if (sc_reset) begin
            r_locked  <= 1'b0;
            r_lock_id <= '0;
        end else if (w_push) begin
            r_locked  <= !w_in_payld[LAST_BIT];
            r_lock_id <= w_sel;
        end
    end
`endif
endmodule

// File: tb/tb_sc_arb_node.sv
// tb_sc_arb_node: directed self-checking bench for sc_arb_node (NUM_SI=2, FIFO_DEPTH=4, 16-bit payload).
module tb_sc_arb_node;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;
    logic [15:0] q[$];
    int   j;

    sc_arb_node_if #(.NUM_SI(2), .PAYLD_W(16), .INFO_W(1)) bus ();

    sc_arb_node #(.NUM_SI(2), .PAYLD_W(16), .INFO_W(1), .FIFO_DEPTH(4), .LAST_BIT(0)) dut (
        .sc_clk  (clk),
        .sc_reset(rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [1:0] send, input logic [15:0] p0, input logic [15:0] p1, input logic mr);
        bus.s_sc_send  = send;
        bus.s_sc_payld = {p1, p0};
        bus.m_sc_recv  = mr;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        drive(2'b00, 16'h0, 16'h0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        bus.s_sc_info = 2'b10;
        drive(2'b11, 16'h0, 16'h0, 1'b1);
        @(negedge clk);
        #1;
        chk("rst_recv", bus.s_sc_recv, 2'b00);
        chk("rst_send", bus.m_sc_send, 1'b0);
        chk("rst_req", bus.m_sc_req, 1'b0);
        chk("rst_payld", bus.m_sc_payld, 16'h0);
        chk("rst_id", bus.m_sc_id, 1'b0);
        do_reset();

        // single source stream
        @(negedge clk); drive(2'b01, 16'hA, 16'h0, 1'b1); #1;
        chk("t1_recv", bus.s_sc_recv, 2'b01);
        chk("t1_send0", bus.m_sc_send, 1'b0);
        @(negedge clk); drive(2'b01, 16'hB, 16'h0, 1'b1); #1;
        chk("t1_pA", bus.m_sc_payld, 16'hA);
        chk("t1_id", bus.m_sc_id, 1'b0);
        @(negedge clk); drive(2'b01, 16'hC, 16'h0, 1'b1); #1;
        chk("t1_pB", bus.m_sc_payld, 16'hB);
        @(negedge clk); drive(2'b00, 16'h0, 16'h0, 1'b1); #1;
        chk("t1_pC", bus.m_sc_payld, 16'hC);
        chk("t1_send3", bus.m_sc_send, 1'b1);
        @(negedge clk); #1;
        chk("t1_idle", bus.m_sc_send, 1'b0);
        chk("t1_pz", bus.m_sc_payld, 16'h0);

        // both sources: alternate grants
        do_reset();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk); drive(2'b11, 16'(16'h1000 + k), 16'(16'h2000 + k), 1'b1); #1;
            chk("t2_recv", bus.s_sc_recv, (k % 2) ? 2'b10 : 2'b01);
            if (k > 0) begin
                chk("t2_id", bus.m_sc_id, 64'((k - 1) % 2));
                chk("t2_info", bus.m_sc_info, 64'((k - 1) % 2));
                chk("t2_payld", bus.m_sc_payld, ((k - 1) % 2) ? 64'(16'h2000 + k - 1) : 64'(16'h1000 + k - 1));
            end
        end
        @(negedge clk); drive(2'b00, 16'h0, 16'h0, 1'b1); #1;
        chk("t2_last", bus.m_sc_payld, 16'h2005);

        // fill to full, then drain with a stall cycle at full
        do_reset();
        j = 0;
        q.delete();
        for (int c = 0; c < 14; c++) begin
            @(negedge clk); drive({1'b0, j < 6}, 16'(j + 1), 16'h0, c >= 5); #1;
            if (c == 4) begin
                chk("t3_full_recv", bus.s_sc_recv, 2'b00);
                chk("t3_count", dut.r_count, 3'd4);
            end
            if (c == 5) chk("t3_pop_full_recv", bus.s_sc_recv, 2'b00);
            if (c == 6) chk("t3_after_recv", bus.s_sc_recv, 2'b01);
            if (bus.m_sc_send && bus.m_sc_recv) q.push_back(bus.m_sc_payld);
            if (bus.s_sc_recv[0]) j++;
        end
        chk("t3_nout", q.size(), 6);
        for (int i = 0; i < 6 && i < q.size(); i++) chk("t3_order", q[i], 64'(i + 1));

        // simultaneous push and pop at count 2
        do_reset();
        @(negedge clk); drive(2'b01, 16'h31, 16'h0, 1'b0);
        @(negedge clk); drive(2'b01, 16'h32, 16'h0, 1'b0);
        @(negedge clk); drive(2'b01, 16'h33, 16'h0, 1'b1); #1;
        chk("t4_head0", bus.m_sc_payld, 16'h31);
        chk("t4_cnt0", dut.r_count, 3'd2);
        @(negedge clk); drive(2'b00, 16'h0, 16'h0, 1'b1); #1;
        chk("t4_cnt1", dut.r_count, 3'd2);
        chk("t4_head1", bus.m_sc_payld, 16'h32);
        @(negedge clk); #1;
        chk("t4_head2", bus.m_sc_payld, 16'h33);
        @(negedge clk); #1;
        chk("t4_empty", bus.m_sc_send, 1'b0);

        // reset mid-operation
        do_reset();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); drive(2'b01, 16'(16'h40 + c), 16'h0, 1'b0);
        end
        @(negedge clk); drive(2'b11, 16'h50, 16'h51, 1'b0); rst = 1'b1; #1;
        chk("t5_cnt_pre", dut.r_count, 3'd3);
        chk("t5_recv_rst", bus.s_sc_recv, 2'b00);
        @(negedge clk); #1;
        chk("t5_send", bus.m_sc_send, 1'b0);
        chk("t5_cnt", dut.r_count, 3'd0);
        chk("t5_recv_rst2", bus.s_sc_recv, 2'b00);
        rst = 1'b0; #1;
        chk("t5_first", bus.s_sc_recv, 2'b01);

`ifdef SC_ARB_NODE_PKT_LOCK_EN
        // packet lock: SI1 three-beat packet stays contiguous
        do_reset();
        j = 0;
        for (int c = 0; c < 6; c++) begin
            logic [15:0] p1;
            logic [1:0]  exp_r;
            p1 = (j == 0) ? 16'h0B10 : (j == 1) ? 16'h0B20 : 16'h0B31;
            exp_r = (c == 0 || c == 4) ? 2'b01 : (c == 5) ? 2'b10 : 2'b10;
            @(negedge clk); drive({j < 3, 1'b1}, 16'h0101, p1, 1'b1); #1;
            if (c < 5) chk("t6_recv", bus.s_sc_recv, exp_r);
            if (c > 0) chk("t6_id", bus.m_sc_id, (c == 1 || c == 5) ? 1'b0 : 1'b1);
            if (bus.s_sc_recv[1]) j++;
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
